// File: rtl/plru_replacement_state_pkg.sv
// ---------------------------------------------------------------------------
// plru_pkg
// Shared definitions for the tree pseudo-LRU replacement state:
//   - default associativity / set-count exponents
//   - node_count(): number of tree nodes for a given associativity
//   - node_depth(): depth of a heap-indexed node (root = depth 0)
//   - fsm_state_t : INIT (sweep clears every set) / RUN (normal traffic)
// ---------------------------------------------------------------------------
package plru_pkg;

    localparam int WAYS_LOG2_DEFAULT = 2;
    localparam int SETS_LOG2_DEFAULT = 6;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // A binary tree over 2**ways_log2 leaves has one fewer internal node.
    function automatic int node_count(input int ways_log2);
        return (1 << ways_log2) - 1;
    endfunction

    // Heap layout: nodes 2**d-1 .. 2**(d+1)-2 live at depth d.
    function automatic int node_depth(input int node);
        int d;
        int n;
        d = 0;
        n = node + 1;
        while (n > 1) begin
            n = n >> 1;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/plru_replacement_state_if.sv
// ---------------------------------------------------------------------------
// plru_replacement_state_if
// Access / victim-query bus between the cache controller (master) and the
// PLRU state block (slave).
//   access_valid/access_set/access_way : hit or fill touch (master -> slave)
//   victim_req/victim_set              : victim query     (master -> slave)
//   way_valid                          : line-valid bits of victim_set,
//                                        only with PLRU_INVALID_FIRST_EN
//   ready                              : init sweep done  (slave -> master)
//   victim_valid/victim_way            : query answer     (slave -> master)
// ---------------------------------------------------------------------------
interface plru_replacement_state_if #(
    parameter int WAYS_LOG2 = plru_pkg::WAYS_LOG2_DEFAULT,
    parameter int SETS_LOG2 = plru_pkg::SETS_LOG2_DEFAULT
);
    logic                   ready;
    logic                   access_valid;
    logic [SETS_LOG2-1:0]   access_set;
    logic [WAYS_LOG2-1:0]   access_way;
    logic                   victim_req;
    logic [SETS_LOG2-1:0]   victim_set;
    logic                   victim_valid;
    logic [WAYS_LOG2-1:0]   victim_way;
`ifdef PLRU_INVALID_FIRST_EN
    logic [(1<<WAYS_LOG2)-1:0] way_valid;
`endif

    modport master (
        input  ready,
        output access_valid,
        output access_set,
        output access_way,
        output victim_req,
        output victim_set,
`ifdef PLRU_INVALID_FIRST_EN
        output way_valid,
`endif
        input  victim_valid,
        input  victim_way
    );

    modport slave (
        output ready,
        input  access_valid,
        input  access_set,
        input  access_way,
        input  victim_req,
        input  victim_set,
`ifdef PLRU_INVALID_FIRST_EN
        input  way_valid,
`endif
        output victim_valid,
        output victim_way
    );

endinterface

// File: rtl/plru_replacement_state_tree_logic.sv
// ---------------------------------------------------------------------------
// plru_tree_logic
// Purely combinational tree pseudo-LRU helpers, heap-indexed tree
// (node 0 = root, children of k are 2k+1 / 2k+2; bit 0 = victim in the
// lower half, bit 1 = upper half).
//   upd_tree/upd_way -> upd_tree_next : tree after touching upd_way
//   vic_tree         -> vic_way       : way reached by following the bits
// The two functions are independent so the top can feed the victim side
// with either the stored tree or the freshly updated one.
// ---------------------------------------------------------------------------
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter  int WAYS_LOG2 = WAYS_LOG2_DEFAULT,
    localparam int NODES     = node_count(WAYS_LOG2)
) (
    input  logic [NODES-1:0]     upd_tree,
    input  logic [WAYS_LOG2-1:0] upd_way,
    output logic [NODES-1:0]     upd_tree_next,
    input  logic [NODES-1:0]     vic_tree,
    output logic [WAYS_LOG2-1:0] vic_way
);

    // A node at depth d, position p within its level, lies on the path to
    // way w exactly when the top d bits of w equal p. Path nodes are set to
    // point away from w; all others keep their value.
    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_node
            localparam int                   DEPTH = node_depth(gi);
            localparam logic [WAYS_LOG2-1:0] POS   = WAYS_LOG2'(gi + 1 - (1 << DEPTH));
            logic on_path;
            assign on_path           = ((upd_way >> (WAYS_LOG2 - DEPTH)) == POS);
            assign upd_tree_next[gi] = on_path ? ~upd_way[WAYS_LOG2-1-DEPTH] : upd_tree[gi];
        end
    endgenerate

    // Root-to-leaf walk; each bit taken is shifted in as the next lower
    // bit of the victim index.
    logic [WAYS_LOG2-1:0] walk_node;
    logic [WAYS_LOG2-1:0] walk_way;
    logic                 walk_bit;

    always_comb begin
        walk_node = '0;
        walk_way  = '0;
        walk_bit  = 1'b0;
        for (int d = 0; d < WAYS_LOG2; d++) begin
            walk_bit  = vic_tree[walk_node];
            walk_way  = (walk_way << 1) | WAYS_LOG2'(walk_bit);
            walk_node = (walk_node << 1) + WAYS_LOG2'(1) + WAYS_LOG2'(walk_bit);
        end
        vic_way = walk_way;
    end

endmodule

// File: rtl/plru_replacement_state.sv
// ---------------------------------------------------------------------------
// plru_replacement_state
// Per-set tree pseudo-LRU state. Touches (hits/fills) update the set's tree
// at the sampling edge; victim queries are answered one cycle later.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; restarts the init sweep
//   bus  : plru_replacement_state_if.slave (access, victim query, ready)
// After reset an INIT sweep writes all-zero trees, one set per cycle; ready
// rises when the sweep has finished and traffic is ignored until then.
// A query to the set being touched in the same cycle sees the post-update
// tree, so a just-touched way is never offered as victim.
// Optional feature macro PLRU_INVALID_FIRST_EN: a query whose way_valid has
// any zero bit returns the lowest-index invalid way instead of the tree
// victim.
// ---------------------------------------------------------------------------
module plru_replacement_state
    import plru_pkg::*;
#(
    parameter int WAYS_LOG2 = WAYS_LOG2_DEFAULT,
    parameter int SETS_LOG2 = SETS_LOG2_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    plru_replacement_state_if.slave bus
);

    localparam int NODES = node_count(WAYS_LOG2);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam logic [SETS_LOG2-1:0] LAST_SET = SETS_LOG2'(SETS - 1);

    fsm_state_t             state_q, state_d;
    logic [SETS_LOG2-1:0]   sweep_q, sweep_d;
    logic                   ready_q, ready_d;
    logic                   victim_valid_q, victim_valid_d;
    logic [WAYS_LOG2-1:0]   victim_way_q, victim_way_d;

    logic [NODES-1:0]       tree_mem [SETS];

    logic                   run;
    logic                   access_fire;
    logic                   bypass;
    logic [NODES-1:0]       acc_tree;
    logic [NODES-1:0]       acc_tree_next;
    logic [NODES-1:0]       vic_tree_raw;
    logic [NODES-1:0]       vic_tree;
    logic [WAYS_LOG2-1:0]   tree_victim;
    logic [WAYS_LOG2-1:0]   victim_sel;

    logic                   mem_we;
    logic [SETS_LOG2-1:0]   mem_waddr;
    logic [NODES-1:0]       mem_wdata;

    assign run          = (state_q == RUN);
    assign access_fire  = run & bus.access_valid;
    assign acc_tree     = tree_mem[bus.access_set];
    assign vic_tree_raw = tree_mem[bus.victim_set];

    // Same-set touch and query: answer from the tree being written this edge.
    assign bypass   = access_fire & (bus.access_set == bus.victim_set);
    assign vic_tree = bypass ? acc_tree_next : vic_tree_raw;

    plru_tree_logic #(
        .WAYS_LOG2 (WAYS_LOG2)
    ) u_tree_logic (
        .upd_tree      (acc_tree),
        .upd_way       (bus.access_way),
        .upd_tree_next (acc_tree_next),
        .vic_tree      (vic_tree),
        .vic_way       (tree_victim)
    );

`ifdef PLRU_INVALID_FIRST_EN
    // Lowest-index invalid way wins; scanning downwards lets it overwrite.
    logic                      any_invalid;
    logic [WAYS_LOG2-1:0]      first_invalid;
    logic [(1<<WAYS_LOG2)-1:0] valid_shift;

    assign any_invalid = ~(&bus.way_valid);

    always_comb begin
        first_invalid = '0;
        valid_shift   = '0;
        for (int i = (1 << WAYS_LOG2) - 1; i >= 0; i--) begin
            valid_shift = bus.way_valid >> i;
            if (!valid_shift[0]) begin
                first_invalid = WAYS_LOG2'(i);
            end
        end
    end

    assign victim_sel = any_invalid ? first_invalid : tree_victim;
`else
    assign victim_sel = tree_victim;
`endif

    // Single write port: the sweep owns it during INIT, touches during RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.access_set;
        mem_wdata = acc_tree_next;
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
        end else if (access_fire) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            tree_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        ready_d        = ready_q;
        victim_valid_d = 1'b0;
        victim_way_d   = victim_way_q;
        case (state_q)
            INIT: begin
                ready_d = 1'b0;
                sweep_d = sweep_q + SETS_LOG2'(1);
                if (sweep_q == LAST_SET) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                ready_d        = 1'b1;
                victim_valid_d = bus.victim_req;
                if (bus.victim_req) begin
                    victim_way_d = victim_sel;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT;
            sweep_q        <= '0;
            ready_q        <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            ready_q        <= ready_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;

endmodule

// File: tb/tb_plru_replacement_state.sv
// ---------------------------------------------------------------------------
// tb_plru_replacement_state
// Directed steps followed by a randomised run, all checked against a
// per-set tree model that applies the touch/victim rules with plain
// integer arithmetic. Define PLRU_INVALID_FIRST_EN to include the
// invalid-first steps.
// ---------------------------------------------------------------------------
module tb_plru_replacement_state;

    localparam int W     = 2;
    localparam int S     = 6;
    localparam int WAYS  = 1 << W;
    localparam int SETS  = 1 << S;
    localparam int NODES = WAYS - 1;

    logic clk;
    logic rst;

    int tests;
    int fails;

    bit model [SETS][NODES];

    plru_replacement_state_if #(.WAYS_LOG2(W), .SETS_LOG2(S)) bus ();

    plru_replacement_state #(
        .WAYS_LOG2 (W),
        .SETS_LOG2 (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < NODES; n++)
                model[s][n] = 1'b0;
    endtask

    // Every node on the root-to-leaf path of w is made to point away from w.
    task automatic model_touch(input int s, input int w);
        int node;
        int b;
        node = 0;
        for (int d = 0; d < W; d++) begin
            b = (w >> (W - 1 - d)) & 1;
            model[s][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
    endtask

    function automatic int model_victim(input int s, input logic [WAYS-1:0] wv);
        int node;
        int v;
        int b;
`ifdef PLRU_INVALID_FIRST_EN
        for (int i = 0; i < WAYS; i++)
            if (!wv[i]) return i;
`endif
        node = 0;
        v    = 0;
        for (int d = 0; d < W; d++) begin
            b    = model[s][node] ? 1 : 0;
            v    = v * 2 + b;
            node = 2 * node + 1 + b;
        end
        return v;
    endfunction

    task automatic drive_idle();
        bus.access_valid = 1'b0;
        bus.access_set   = '0;
        bus.access_way   = '0;
        bus.victim_req   = 1'b0;
        bus.victim_set   = '0;
`ifdef PLRU_INVALID_FIRST_EN
        bus.way_valid    = '1;
`endif
    endtask

    // One RUN-mode cycle: drive at the negedge, let the DUT sample, check at
    // the following negedge. The model applies the touch before the query,
    // which gives the same-set bypass and leaves other sets untouched.
    task automatic cycle(input logic av, input int aset, input int away,
                         input logic vr, input int vset, input logic [WAYS-1:0] wv,
                         input int exp_const, input string tag);
        int exp;
        bus.access_valid = av;
        bus.access_set   = S'(aset);
        bus.access_way   = W'(away);
        bus.victim_req   = vr;
        bus.victim_set   = S'(vset);
`ifdef PLRU_INVALID_FIRST_EN
        bus.way_valid    = wv;
`endif
        if (av) model_touch(aset, away);
        exp = vr ? model_victim(vset, wv) : 0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vvalid"}, bus.victim_valid, vr);
        if (vr) begin
            check({tag, "_model"}, bus.victim_way, exp);
            if (exp_const >= 0) check({tag, "_const"}, bus.victim_way, exp_const);
        end
        $display("[TB] %s acc=%0b s%0d w%0d req=%0b s%0d vv=%0b way=%0d exp=%0d",
                 tag, av, aset, away, vr, vset, bus.victim_valid, bus.victim_way, exp);
    endtask

    // Reset with traffic asserted throughout; the sweep must ignore it and
    // last exactly SETS cycles after rst falls.
    task automatic do_reset(input string tag);
        int cnt;
        rst              = 1'b1;
        bus.access_valid = 1'b1;
        bus.access_set   = 6'd3;
        bus.access_way   = 2'd1;
        bus.victim_req   = 1'b1;
        bus.victim_set   = 6'd3;
        repeat (2) @(negedge clk);
        check({tag, "_rst_ready"}, bus.ready, 1'b0);
        check({tag, "_rst_vvalid"}, bus.victim_valid, 1'b0);
        check({tag, "_rst_vway"}, bus.victim_way, 0);
        model_clear();
        rst = 1'b0;
        cnt = 0;
        while (!bus.ready && cnt < 200) begin
            bus.access_valid = 1'($urandom_range(0, 1));
            bus.access_set   = S'($urandom_range(0, SETS - 1));
            bus.access_way   = W'($urandom_range(0, WAYS - 1));
            @(negedge clk);
            cnt++;
            if (!bus.ready) check({tag, "_init_vvalid"}, bus.victim_valid, 1'b0);
        end
        check({tag, "_init_len"}, cnt, SETS);
        check({tag, "_ready"}, bus.ready, 1'b1);
        drive_idle();
        $display("[TB] %s sweep done after %0d cycles", tag, cnt);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive_idle();

        do_reset("por");
        cycle(0, 0, 0, 1, 5, 4'hF, 0, "q_set5");

        // Rotating touches on set 3, each queried the following cycle.
        cycle(1, 3, 0, 0, 0, 4'hF, -1, "s3_acc0");
        cycle(0, 0, 0, 1, 3, 4'hF, 2,  "s3_vic_a");
        cycle(1, 3, 2, 0, 0, 4'hF, -1, "s3_acc2");
        cycle(0, 0, 0, 1, 3, 4'hF, 1,  "s3_vic_b");
        cycle(1, 3, 1, 0, 0, 4'hF, -1, "s3_acc1");
        cycle(0, 0, 0, 1, 3, 4'hF, 3,  "s3_vic_c");
        cycle(1, 3, 3, 0, 0, 4'hF, -1, "s3_acc3");
        cycle(0, 0, 0, 1, 3, 4'hF, 0,  "s3_vic_d");

        // Same-cycle touch and query.
        cycle(1, 7, 0, 1, 7, 4'hF, 2, "bypass_s7");
        cycle(1, 7, 1, 1, 8, 4'hF, 0, "indep_s8");

        // Reset in the middle of traffic.
        cycle(1, 3, 0, 0, 0, 4'hF, -1, "pre_rst_acc");
        cycle(1, 3, 1, 1, 3, 4'hF, 2,  "pre_rst_q");
        do_reset("mid");
        cycle(0, 0, 0, 1, 3, 4'hF, 0, "post_rst_s3");

`ifdef PLRU_INVALID_FIRST_EN
        cycle(1, 4, 0, 0, 0, 4'hF, -1, "inv_setup");
        cycle(0, 0, 0, 1, 4, 4'b1011, 2, "inv_1011");
        cycle(0, 0, 0, 1, 4, 4'b1111, 2, "inv_1111");
        cycle(0, 0, 0, 1, 4, 4'b0110, 0, "inv_0110");
`endif

        // Randomised traffic on a few sets so same-set bypass is frequent.
        for (int i = 0; i < 10000; i++) begin
            int aset;
            int vset;
            logic [WAYS-1:0] wv;
            aset = $urandom_range(0, 7);
            vset = ($urandom_range(0, 1) == 1) ? aset : $urandom_range(0, 7);
            wv   = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
            cycle(1'($urandom_range(0, 1)), aset, $urandom_range(0, WAYS - 1),
                  1'($urandom_range(0, 1)), vset, wv, -1, "rand");
        end

        drive_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/plru_replacement_state.md
Name: plru_replacement_state

Overview:
- Per-set tree pseudo-LRU state for the set-associative cache; sits directly downstream of the one-hot→binary way encoder.
- Consumes the binary way index of each hit or fill and updates that set's tree bits.
- Answers victim queries with the binary index of the pseudo-least-recently-used way, for the fill/write controller.

Parameters:
- WAYS_LOG2, 2, log2 of associativity. Ways = 2**WAYS_LOG2; tree nodes = 2**WAYS_LOG2 - 1.
- SETS_LOG2, 6, log2 of the set count. Also sets the init sweep length.

Ports:
- clk  in  1  Sole clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- ready  out  1  High once the init sweep is complete.
- access_valid  in  1  Hit/fill touch this cycle.
- access_set  in  SETS_LOG2  Set being touched.
- access_way  in  WAYS_LOG2  Binary way touched, from the encoder.
- victim_req  in  1  Victim query.
- victim_set  in  SETS_LOG2  Set queried.
- victim_valid  out  1  victim_way is valid this cycle.
- victim_way  out  WAYS_LOG2  Binary index of the PLRU way.
- way_valid  in  2**WAYS_LOG2  Line-valid bits of victim_set. Present only with PLRU_INVALID_FIRST_EN.

Behaviour:
- Storage: one tree vector per set, 2**SETS_LOG2 entries × (2**WAYS_LOG2 - 1) bits, heap-indexed. Node 0 is the root; children of node k are 2k+1 and 2k+2.
- Node semantics: bit 0 = victim lies in the lower-numbered half; bit 1 = upper half.
- Update on access to way w: walk root to leaf. At depth d, the visited node gets ~w[WAYS_LOG2-1-d], so every node on the path points away from w. Nodes off the path are unchanged.
- Victim: walk from the root following node bits. The bit taken at depth d becomes victim_way[WAYS_LOG2-1-d].
- FSM states are INIT and RUN.
- INIT: entered on rst from any state, including mid-operation. A sweep counter starts at 0 and writes all-zero tree bits to one set per cycle. After set 2**SETS_LOG2-1 is written, the FSM moves to RUN the next cycle. ready=0 throughout; access_valid and victim_req are ignored.
- RUN: ready=1. An access is written at the clock edge where it is sampled.
- Victim latency: a request sampled at edge t gives victim_valid=1 and victim_way for exactly the cycle after t. No backpressure.
- Same-set bypass: if access_valid and victim_req hit the same set in one cycle, the victim is computed from the post-update tree. A just-touched way is never returned.
- Different sets in one cycle: fully independent.
- Back-to-back accesses to one set: each sees the prior update, with no hazard.
- Reset values: ready=0, victim_valid=0, victim_way=0, FSM=INIT, sweep counter=0.
- Tree bits are undefined until swept. They are never observed before ready=1.

Optional Feature:
- Macro: PLRU_INVALID_FIRST_EN.
- Defined: the way_valid port exists. If any bit is 0, victim_way is the lowest-index invalid way, and the tree is neither consulted nor modified by the query. If all bits are 1, the tree victim is returned. Latency and bypass rules are unchanged; way_valid is sampled with victim_req.
- Undefined: way_valid is absent and the victim always comes from the tree.

Decomposition:
- Package plru_pkg holds:
  - the default WAYS_LOG2 and SETS_LOG2 constants;
  - a node-count function;
  - the FSM state enum {INIT, RUN}.
- One combinational sub-module, plru_tree_logic. Inputs: tree bits and a way. Outputs: updated tree bits and the victim way from a given tree.
- The top level is instantiated once per cache.

Test Plan:
- Reset, WAYS_LOG2=2, SETS_LOG2=6 → ready low for exactly 64 cycles after rst falls, then high. Query set 5 → victim_way=0 one cycle later.
- Set 3: access way 0 → victim 2; then access way 2 → victim 1; then access way 1 → victim 3; then access way 3 → victim 0.
- Same cycle: access set 7 way 0 and query set 7 → victim_way=2 (bypass); query set 8 in the same cycle → victim_way=0 (independent set).
- Reassert rst mid-traffic after updates to set 3 → ready drops, requests are ignored (victim_valid=0). After the sweep, set 3 victim=0.
- PLRU_INVALID_FIRST_EN, set 4 tree pointing to way 2, way_valid=4'b1011 → victim 2. way_valid=4'b1111 → tree victim. way_valid=4'b0110 → victim 0.
- Randomised accesses against a reference tree model over 10k cycles, including same-set bypass → every victim matches.
